mult16_operand_sequencer: RTL and testbench
===========================================

// Module: mult16_operand_sequencer
// PURPOSE
//  Upstream feeder for the team's 16-bit shift-add multiplier (start/ain/bin in; yout/done out).
//  - Queues operand pairs from a valid/ready source.
//  - Holds the multiplier's start high for a fixed run window, then drops it.
//  - Captures each product and presents it on a valid/ready result port.
//  - The multiplier never clears its product register between runs, so the product is (yout at end) - (yout at start), mod 2^32.
// PARAMETERS
//  FIFO_DEPTH  4   operand-pair queue entries; power of 2, >= 2
//  RUN_CYCLES  18  cycles mul_start is held high per operation; >= 17
// PORTS
//  clk         in   1   single clock; all logic on posedge
//  rst         in   1   synchronous, active-high reset
//  in_valid    in   1   operand pair valid
//  in_ready    out  1   queue can accept; = !full
//  in_a        in   16  multiplicand
//  in_b        in   16  multiplier
//  fifo_level  out  $clog2(FIFO_DEPTH+1)  queued pairs
//  mul_start   out  1   to multiplier start
//  mul_ain     out  16  to multiplier ain
//  mul_bin     out  16  to multiplier bin
//  mul_yout    in   32  from multiplier yout
//  mul_done    in   1   from multiplier done
//  res_valid   out  1   result valid
//  res_ready   in   1   result accepted
//  res_data    out  32  product a*b
//  res_err     out  1   mul_done never sampled high during the run
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//  - FSM -> IDLE; queue emptied; cycle counter cleared.
//  - in_ready=1 on the cycle after reset; all other outputs=0.
//  - Reset mid-operation drops the in-flight op and all queued ops; mul_start=0 next cycle.
//  Queue:
//  - Push when in_valid && in_ready.
//  - When full, in_ready=0 even if a pop happens in the same cycle.
//  - Simultaneous push+pop when not full leaves fifo_level unchanged.
//  - Order is preserved; pointers wrap modulo FIFO_DEPTH.
//  FSM states:
//  - IDLE: if fifo_level != 0, pop the head into mul_ain/mul_bin, base <= mul_yout,
//    clear done_seen and the counter; go to RUN.
//  - RUN: mul_start=1. Counter counts 0..RUN_CYCLES-1; done_seen |= mul_done each cycle.
//    At count RUN_CYCLES-1 go to CAPT, so mul_start is high for exactly RUN_CYCLES cycles.
//  - CAPT: mul_start=0. res_data <= mul_yout - base (32-bit wrap);
//    res_err <= !done_seen; res_valid <= 1; go to OUT.
//  - OUT: res_valid=1. res_data and res_err are held stable until res_ready.
//    On res_valid && res_ready: res_valid <= 0, go to IDLE.
//  Timing:
//  - mul_ain/mul_bin are stable from the IDLE pop until the next pop.
//  - mul_start is low for >= 2 cycles between runs (CAPT plus OUT at minimum), so the multiplier's counter clears.
//  - Latency with res_ready=1: RUN_CYCLES+2 cycles from pop to res_valid.
//  - Throughput: one op per RUN_CYCLES+3 cycles.
//  - The queue keeps accepting pairs in every state.
// TESTING
//  Bench uses a behavioural model of the multiplier: accumulates a*b into a non-cleared 32-bit yout;
//  done pulses high at count 16. Directed scenarios:
//  1. Reset, push (3,5), res_ready=1 -> mul_start high 18 cycles; res_valid=1 with res_data=0x0000000F, res_err=0, 20 cycles after the pop.
//  2. Preload model yout=0x12345678, push (0xFFFF,0xFFFF) -> res_data=0xFFFE0001 (subtraction wrap correct).
//  3. Hold res_ready=0; push 5 pairs back-to-back -> 1 popped, next 4 fill the queue; in_ready=0, fifo_level=4.
//     Release res_ready -> results in push order: (1,2)=2, (3,4)=12, (0x100,0x100)=0x10000, (0,0x1234)=0, (7,9)=63.
//  4. res_ready=0 for 10 cycles during OUT -> res_data/res_valid stable; single accept; returns to IDLE.
//  5. Assert rst at RUN count 5 with 2 pairs queued -> next cycle: mul_start=0, fifo_level=0, res_valid=0; no result produced.
//  6. Model with done tied 0, push (2,2) -> res_data=4, res_err=1; next op with done restored -> res_err=0.

Source files
------------

// File: rtl/mult16_operand_sequencer.sv
// Operand-pair queue and run sequencer in front of the 16-bit shift-add
// multiplier. Pairs are queued from a valid/ready source, each one is run for
// a fixed window of mul_start cycles, and the product is returned on a
// valid/ready result port. The multiplier never clears its accumulator, so
// the product is taken as the difference of yout across the run.
module mult16_operand_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int RUN_CYCLES = 18
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [15:0]                       in_a,
    input  logic [15:0]                       in_b,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              mul_start,
    output logic [15:0]                       mul_ain,
    output logic [15:0]                       mul_bin,
    input  logic [31:0]                       mul_yout,
    input  logic                              mul_done,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic [31:0]                       res_data,
    output logic                              res_err
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int CW = $clog2(RUN_CYCLES);

    typedef enum logic [1:0] {IDLE, RUN, CAPT, OUT} state_t;

    state_t         state, state_nxt;
    logic [15:0]    mem_a [FIFO_DEPTH];
    logic [15:0]    mem_b [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [LW-1:0]  level;
    logic [CW-1:0]  cnt;
    logic [31:0]    base;
    logic           done_seen;
    logic           push, pop, full;

    // Full blocks pushes even if a pop frees a slot this cycle.
    assign full       = (level == LW'(FIFO_DEPTH));
    assign in_ready   = !full;
    assign push       = in_valid && in_ready;
    assign pop        = (state == IDLE) && (level != '0);
    assign fifo_level = level;

    // Queue storage; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

    // Queue pointers and occupancy; pointers wrap at FIFO_DEPTH (power of 2).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and start strobe; start is high only while in RUN.
    always_comb begin
        state_nxt = state;
        mul_start = 1'b0;
        case (state)
            IDLE: if (pop) state_nxt = RUN;
            RUN: begin
                mul_start = 1'b1;
                if (cnt == CW'(RUN_CYCLES - 1)) state_nxt = CAPT;
            end
            CAPT: state_nxt = OUT;
            OUT:  if (res_valid && res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, run counter, done tracking and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_ain   <= '0;
            mul_bin   <= '0;
            base      <= '0;
            done_seen <= 1'b0;
            cnt       <= '0;
            res_data  <= '0;
            res_err   <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (pop) begin
                    mul_ain   <= mem_a[rd_ptr];
                    mul_bin   <= mem_b[rd_ptr];
                    base      <= mul_yout;
                    done_seen <= 1'b0;
                    cnt       <= '0;
                end
                RUN: begin
                    cnt       <= cnt + CW'(1);
                    done_seen <= done_seen | mul_done;
                end
                CAPT: begin
                    res_data  <= mul_yout - base;
                    res_err   <= !done_seen;
                    res_valid <= 1'b1;
                end
                OUT: if (res_ready) res_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult16_operand_sequencer.sv
// Directed bench for mult16_operand_sequencer with a behavioural shift-add
// multiplier model and a result scoreboard.
module tb_mult16_operand_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0, in_b = '0;
    logic [2:0]  fifo_level;
    logic        mul_start;
    logic [15:0] mul_ain, mul_bin;
    logic [31:0] mul_yout;
    logic        mul_done;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [31:0] res_data;
    logic        res_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mult16_operand_sequencer #(.FIFO_DEPTH(4), .RUN_CYCLES(18)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .fifo_level(fifo_level),
        .mul_start(mul_start), .mul_ain(mul_ain), .mul_bin(mul_bin),
        .mul_yout(mul_yout), .mul_done(mul_done), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_err(res_err)
    );

    // Multiplier model: accumulates a*b into a never-cleared yout; done at count 16.
    logic [31:0] m_yout = '0;
    logic [4:0]  m_cnt = '0;
    logic        done_en = 1'b1;
    logic        preload_en = 1'b0;
    logic [31:0] preload_val = '0;
    assign mul_yout = m_yout;
    assign mul_done = mul_start && (m_cnt == 5'd16) && done_en;

    always @(posedge clk) begin
        if (preload_en) m_yout <= preload_val;
        else if (mul_start && m_cnt == 5'd16)
            m_yout <= m_yout + 32'(mul_ain) * 32'(mul_bin);
        m_cnt <= mul_start ? ((m_cnt == 5'd31) ? m_cnt : m_cnt + 5'd1) : 5'd0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard: {err, data} expected in push order.
    logic [32:0] exp_q[$];

    // Monitor: compare each accepted result against the head of the queue.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_result: got data 0x%08h err %0d with nothing expected",
                         res_data, res_err);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("res_data", res_data, e[31:0]);
                check("res_err", 32'(res_err), 32'(e[32]));
            end
        end
    end

    // Run-window checker: each uninterrupted start pulse lasts 18 cycles, gaps >= 2.
    int run_len = 0;
    int low_len = 100;
    always @(negedge clk) begin
        if (rst) begin
            run_len = 0;
            low_len = 100;
        end else if (mul_start) begin
            if (run_len == 0) check("start_gap_ge2", 32'(low_len >= 2), 32'd1);
            run_len++;
            low_len = 0;
        end else begin
            if (run_len != 0) check("start_len", 32'(run_len), 32'd18);
            run_len = 0;
            low_len++;
        end
    end

    task automatic push(input logic [15:0] a, input logic [15:0] b);
        int t;
        in_valid = 1'b1; in_a = a; in_b = b;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (!in_ready) check("push_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_res(input logic [31:0] d, input logic err);
        exp_q.push_back({err, d});
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || res_valid || fifo_level != 0 || mul_start) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int t;
        logic [31:0] held;
        logic        stable;

        // Reset
        preload_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; preload_en = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_mul_start", 32'(mul_start), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_fifo_level", 32'(fifo_level), 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_mul_ain", 32'(mul_ain), 32'd0);

        // 1: basic op and pop-to-result latency
        @(posedge clk); #1;
        expect_res(32'h0000000F, 1'b0);
        push(16'd3, 16'd5);
        t = 0;
        while (!mul_start && t < 50) begin @(negedge clk); t++; end
        t = 0;
        while (!res_valid && t < 100) begin @(negedge clk); t++; end
        check("latency_start_to_valid", 32'(t), 32'd19);
        drain("t1_drain");

        // 2: subtraction wraps with a preloaded accumulator
        @(posedge clk); #1 preload_en = 1'b1; preload_val = 32'h12345678;
        @(posedge clk); #1 preload_en = 1'b0;
        expect_res(32'hFFFE0001, 1'b0);
        push(16'hFFFF, 16'hFFFF);
        drain("t2_drain");

        // 3: fill the queue while results are blocked
        @(posedge clk); #1 res_ready = 1'b0;
        expect_res(32'd2, 1'b0);       push(16'd1, 16'd2);
        expect_res(32'd12, 1'b0);      push(16'd3, 16'd4);
        expect_res(32'h10000, 1'b0);   push(16'h100, 16'h100);
        expect_res(32'd0, 1'b0);       push(16'd0, 16'h1234);
        expect_res(32'd63, 1'b0);      push(16'd7, 16'd9);
        @(negedge clk);
        check("t3_in_ready_full", 32'(in_ready), 32'd0);
        check("t3_fifo_level", 32'(fifo_level), 32'd4);
        @(posedge clk); #1 res_ready = 1'b1;
        drain("t3_drain");

        // 4: result held stable while res_ready is low
        @(posedge clk); #1 res_ready = 1'b0;
        expect_res(32'd42, 1'b0);
        push(16'd6, 16'd7);
        t = 0;
        while (!res_valid && t < 100) begin @(negedge clk); t++; end
        check("t4_valid_seen", 32'(res_valid), 32'd1);
        held = res_data;
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!res_valid || res_data !== held) stable = 1'b0;
        end
        check("t4_held_stable", 32'(stable), 32'd1);
        @(posedge clk); #1 res_ready = 1'b1;
        @(posedge clk); #1 res_ready = 1'b0;
        @(negedge clk);
        check("t4_valid_dropped", 32'(res_valid), 32'd0);
        check("t4_sb_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1 res_ready = 1'b1;

        // 5: reset mid-run drops the running op and the queue
        push(16'd10, 16'd10);
        push(16'd11, 16'd11);
        push(16'd12, 16'd12);
        t = 0;
        while (!mul_start && t < 50) begin @(negedge clk); t++; end
        check("t5_running", 32'(mul_start), 32'd1);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("t5_mul_start", 32'(mul_start), 32'd0);
        check("t5_fifo_level", 32'(fifo_level), 32'd0);
        check("t5_res_valid", 32'(res_valid), 32'd0);
        repeat (30) @(negedge clk);
        check("t5_no_result", 32'(res_valid), 32'd0);

        // 6: missing done flags an error, restored done clears it
        @(posedge clk); #1 done_en = 1'b0;
        expect_res(32'd4, 1'b1);
        push(16'd2, 16'd2);
        drain("t6a_drain");
        @(posedge clk); #1 done_en = 1'b1;
        expect_res(32'd25, 1'b0);
        push(16'd5, 16'd5);
        drain("t6b_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
